// File: rtl/prf_scoreboard_file_if.sv
// Bundle between rename/issue/CDB logic and the physical register scoreboard file.
// The master side drives requests; the slave side (the register file) returns read data and status.
interface prf_scoreboard_file_if #(
   parameter int NUM_PREGS = 64,
   parameter int DATA_W    = 32,
   parameter int NUM_WR    = 2,
   parameter int NUM_RD    = 2,
   parameter int NUM_ALLOC = 1
);
   localparam int IW = $clog2(NUM_PREGS);

   logic [NUM_WR-1:0]    wr_en;
   logic [IW-1:0]        wr_preg    [NUM_WR];
   logic [DATA_W-1:0]    wr_data    [NUM_WR];
   logic [NUM_ALLOC-1:0] alloc_en;
   logic [IW-1:0]        alloc_preg [NUM_ALLOC];
   logic                 flush;
   logic [NUM_RD-1:0]    rd_req;
   logic [IW-1:0]        rd_rs1     [NUM_RD];
   logic [IW-1:0]        rd_rs2     [NUM_RD];
   logic [NUM_RD-1:0]    rd_valid;
   logic [DATA_W-1:0]    rd_v1      [NUM_RD];
   logic [DATA_W-1:0]    rd_v2      [NUM_RD];
   logic [NUM_RD-1:0]    rd_rdy1;
   logic [NUM_RD-1:0]    rd_rdy2;
   logic [IW:0]          busy_cnt;
   logic                 init_done;

   modport master (
      output wr_en, wr_preg, wr_data, alloc_en, alloc_preg, flush, rd_req, rd_rs1, rd_rs2,
      input  rd_valid, rd_v1, rd_v2, rd_rdy1, rd_rdy2, busy_cnt, init_done
   );

   modport slave (
      input  wr_en, wr_preg, wr_data, alloc_en, alloc_preg, flush, rd_req, rd_rs1, rd_rs2,
      output rd_valid, rd_v1, rd_v2, rd_rdy1, rd_rdy2, busy_cnt, init_done
   );
endinterface

// File: rtl/prf_scoreboard_file.sv
// Physical register file with per-register ready scoreboard, CDB write bypass and a
// reset-time sweep that zeroes data and marks every register ready before normal operation.
module prf_scoreboard_file #(
   parameter int NUM_PREGS = 64,
   parameter int DATA_W    = 32,
   parameter int NUM_WR    = 2,
   parameter int NUM_RD    = 2,
   parameter int NUM_ALLOC = 1
) (
   input logic                clk,
   input logic                rst_n,
   prf_scoreboard_file_if.slave bus
);
   localparam int IW = $clog2(NUM_PREGS);

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [IW-1:0]        cnt_r;
   logic [IW-1:0]        cnt_nxt_s;
   logic                 run_s;
   logic                 init_done_s;
   logic [NUM_PREGS-1:0] ready_r;
   logic [NUM_PREGS-1:0] ready_nxt_s;
   logic [NUM_PREGS-1:0] wr_hit_s;
   logic [NUM_PREGS-1:0] al_hit_s;
   logic [DATA_W-1:0]    data_r      [NUM_PREGS];
   logic [NUM_RD-1:0]    rd_valid_r;
   logic [DATA_W-1:0]    rd_v1_r     [NUM_RD];
   logic [DATA_W-1:0]    rd_v2_r     [NUM_RD];
   logic [DATA_W-1:0]    rd_v1_nxt_s [NUM_RD];
   logic [DATA_W-1:0]    rd_v2_nxt_s [NUM_RD];
   logic [IW:0]          busy_cnt_r;

   function automatic logic [IW:0] count_zeros(input logic [NUM_PREGS-1:0] v);
      logic [IW:0] n;
      n = {(IW+1){1'b0}};
      for (int j = 0; j < NUM_PREGS; j++) begin
         n = n + {{IW{1'b0}}, ~v[j]};
      end
      return n;
   endfunction

   // FSM state and sweep counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= INIT;
         cnt_r   <= {IW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // FSM next state: sweep every register once, then stay in RUN until reset
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         INIT: begin
            cnt_nxt_s = cnt_r + IW'(1);
            if (cnt_r == IW'(NUM_PREGS - 1)) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = INIT;
            end
         end
         RUN:     state_nxt_s = RUN;
         default: state_nxt_s = INIT;
      endcase
   end

   // FSM outputs
   always_comb begin
      case (state_r)
         RUN:     begin run_s = 1'b1; init_done_s = 1'b1; end
         INIT:    begin run_s = 1'b0; init_done_s = 1'b0; end
         default: begin run_s = 1'b0; init_done_s = 1'b0; end
      endcase
   end

   // Per-register write and alloc hits; register 0 is never a target
   always_comb begin
      wr_hit_s = {NUM_PREGS{1'b0}};
      al_hit_s = {NUM_PREGS{1'b0}};
      for (int i = 0; i < NUM_WR; i++) begin
         wr_hit_s[bus.wr_preg[i]] = wr_hit_s[bus.wr_preg[i]] | (bus.wr_en[i] & run_s);
      end
      for (int k = 0; k < NUM_ALLOC; k++) begin
         al_hit_s[bus.alloc_preg[k]] = al_hit_s[bus.alloc_preg[k]] | (bus.alloc_en[k] & run_s);
      end
      wr_hit_s[0] = 1'b0;
      al_hit_s[0] = 1'b0;
   end

   // Next ready vector: flush beats alloc, alloc beats write
   always_comb begin
      ready_nxt_s = ready_r;
      for (int j = 0; j < NUM_PREGS; j++) begin
         if (j == 0) begin
            ready_nxt_s[j] = 1'b1;
         end else if (!run_s) begin
            ready_nxt_s[j] = ready_r[j] | (cnt_r == IW'(j));
         end else if (bus.flush) begin
            ready_nxt_s[j] = 1'b1;
         end else if (al_hit_s[j]) begin
            ready_nxt_s[j] = 1'b0;
         end else begin
            ready_nxt_s[j] = ready_r[j] | wr_hit_s[j];
         end
      end
   end

   // Ready bits and busy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r    <= {NUM_PREGS{1'b1}};
         busy_cnt_r <= {(IW+1){1'b0}};
      end else begin
         ready_r    <= ready_nxt_s;
         busy_cnt_r <= count_zeros(ready_nxt_s);
      end
   end

   // Data array: zeroed by the sweep, later written by the CDB with the highest port last
   always_ff @(posedge clk) begin
      if (!run_s) begin
         data_r[cnt_r] <= {DATA_W{1'b0}};
      end else begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] && (bus.wr_preg[i] != {IW{1'b0}})) begin
               data_r[bus.wr_preg[i]] <= bus.wr_data[i];
            end
         end
      end
   end

   // Operand selection with same-cycle CDB bypass
   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         rd_v1_nxt_s[r] = data_r[bus.rd_rs1[r]];
         rd_v2_nxt_s[r] = data_r[bus.rd_rs2[r]];
         for (int i = 0; i < NUM_WR; i++) begin
            rd_v1_nxt_s[r] = (run_s && bus.wr_en[i] && (bus.wr_preg[i] == bus.rd_rs1[r]))
                             ? bus.wr_data[i] : rd_v1_nxt_s[r];
            rd_v2_nxt_s[r] = (run_s && bus.wr_en[i] && (bus.wr_preg[i] == bus.rd_rs2[r]))
                             ? bus.wr_data[i] : rd_v2_nxt_s[r];
         end
         rd_v1_nxt_s[r] = (bus.rd_rs1[r] == {IW{1'b0}}) ? {DATA_W{1'b0}} : rd_v1_nxt_s[r];
         rd_v2_nxt_s[r] = (bus.rd_rs2[r] == {IW{1'b0}}) ? {DATA_W{1'b0}} : rd_v2_nxt_s[r];
      end
   end

   // Read port registers; operand values hold when no read is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_r <= {NUM_RD{1'b0}};
         for (int r = 0; r < NUM_RD; r++) begin
            rd_v1_r[r] <= {DATA_W{1'b0}};
            rd_v2_r[r] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int r = 0; r < NUM_RD; r++) begin
            rd_valid_r[r] <= run_s & bus.rd_req[r];
            if (run_s && bus.rd_req[r]) begin
               rd_v1_r[r] <= rd_v1_nxt_s[r];
               rd_v2_r[r] <= rd_v2_nxt_s[r];
            end
         end
      end
   end

   // Wakeup query: a same-cycle CDB write makes the source ready immediately
   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         bus.rd_rdy1[r] = ready_r[bus.rd_rs1[r]] | wr_hit_s[bus.rd_rs1[r]] |
                          (bus.rd_rs1[r] == {IW{1'b0}});
         bus.rd_rdy2[r] = ready_r[bus.rd_rs2[r]] | wr_hit_s[bus.rd_rs2[r]] |
                          (bus.rd_rs2[r] == {IW{1'b0}});
      end
   end

   assign bus.rd_valid  = rd_valid_r;
   assign bus.rd_v1     = rd_v1_r;
   assign bus.rd_v2     = rd_v2_r;
   assign bus.busy_cnt  = busy_cnt_r;
   assign bus.init_done = init_done_s;
endmodule
